// File: rtl/data_mem_pkg.sv
// Shared definitions for the handshaked data memory: RV32 load/store funct3 codes,
// the controller state encoding and the funct3 legality check.
package data_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Stores only exist in signed widths; loads add the unsigned byte/half forms.
    function automatic logic f3_unsupported(input logic we, input logic [2:0] f3);
        if (we) begin
            return !(f3 inside {F3_B, F3_H, F3_W});
        end
        return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response bus between the core MEM stage (master) and the data memory (slave).
interface data_mem_hs_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_lane.sv
// Byte-lane logic for one 32-bit RAM word: store merge, load extract/extend and
// the alignment check. Purely combinational, little-endian (lane 0 = bits 7:0).
module data_mem_lane
    import data_mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    output logic [31:0] merged_word,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = old_word[{addr, 3'b000} +: 8];
    assign half_sel = old_word[{addr[1], 4'b0000} +: 16];

    always_comb begin
        merged_word = old_word;
        case (funct3)
            F3_B:    merged_word[{addr, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    merged_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    merged_word = wdata;
            default: merged_word = old_word;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            F3_W:    load_data = old_word;
            default: load_data = 32'h0000_0000;
        endcase
    end

    assign misalign = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0])
                    || ((funct3 == F3_W) && (addr != 2'b00));

endmodule

// File: rtl/data_mem_hs.sv
// Handshaked word-organised data memory for the RV32 MEM stage, with optional wait
// states and error reporting for misaligned, unsupported and out-of-range accesses.
//
// state  | meaning
// IDLE   | req_ready high; accept a request, latch it and classify the error
// WAIT   | burn WAIT_STATES cycles to model a slow array
// ACCESS | write the merged word (store) or register the extended load data
// RESP   | present the response one cycle later and hold it until rsp_ready
module data_mem_hs
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_WORDS   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    data_mem_hs_if.slave  bus
);

    localparam int         IDX_W   = $clog2(MEM_WORDS);
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         off_q, off_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rerr_q, rerr_d;
    logic               rvalid_q, rvalid_d;

    logic [31:0]        mem_q [MEM_WORDS];

    logic               accept;
    logic               rsp_hs;
    logic               range_err;
    logic               mem_we;
    logic [2:0]         lane_f3;
    logic [1:0]         lane_off;
    logic [31:0]        old_word;
    logic [31:0]        merged_word;
    logic [31:0]        load_data;
    logic               misalign;

    assign accept    = (state_q == IDLE) && bus.req_valid;
    assign rsp_hs    = rvalid_q && bus.rsp_ready;
    assign range_err = |bus.req_addr[ADDR_WIDTH-1:IDX_W+2];
    assign mem_we    = (state_q == ACCESS) && we_q && !err_q;
    assign old_word  = mem_q[idx_q];

    // The lane checks the live request while idle (for err) and the latched one afterwards.
    assign lane_f3  = (state_q == IDLE) ? bus.req_funct3   : f3_q;
    assign lane_off = (state_q == IDLE) ? bus.req_addr[1:0] : off_q;

    data_mem_lane u_lane (
        .old_word    (old_word),
        .wdata       (wdata_q),
        .funct3      (lane_f3),
        .addr        (lane_off),
        .merged_word (merged_word),
        .load_data   (load_data),
        .misalign    (misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (cnt_q == WS_LAST) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = rvalid_q;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = rerr_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        we_d     = we_q;
        f3_d     = f3_q;
        idx_d    = idx_q;
        off_d    = off_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        rvalid_d = rvalid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    idx_d   = bus.req_addr[IDX_W+1:2];
                    off_d   = bus.req_addr[1:0];
                    wdata_d = bus.req_wdata;
                    err_d   = range_err || misalign || f3_unsupported(bus.req_we, bus.req_funct3);
                    cnt_d   = 4'd0;
                end
            end
            WAIT: cnt_d = cnt_q + 4'd1;
            ACCESS: begin
                rdata_d = (!err_q && !we_q) ? load_data : 32'h0000_0000;
                rerr_d  = err_q;
            end
            RESP: rvalid_d = !rsp_hs;
            default: rvalid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            idx_q    <= '0;
            off_q    <= 2'b00;
            wdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0000_0000;
            rerr_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            idx_q    <= idx_d;
            off_q    <= off_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Array contents survive reset; only a completed ACCESS edge commits a store.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= merged_word;
        end
    end

endmodule

// File: tb/tb_data_mem_hs.sv
// Scoreboard bench for data_mem_hs: two instances (0 and 3 wait states) driven with
// directed and random load/store traffic against a byte-array reference model.
module tb_data_mem_hs;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_hs_if #(.ADDR_WIDTH(32)) bus0 ();
    data_mem_hs_if #(.ADDR_WIDTH(32)) bus3 ();

    data_mem_hs #(.ADDR_WIDTH(32), .MEM_WORDS(64), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    data_mem_hs #(.ADDR_WIDTH(32), .MEM_WORDS(64), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3));

    logic        req_valid [2];
    logic        req_we    [2];
    logic [2:0]  req_f3    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_ready [2];
    logic        o_req_ready [2];
    logic        o_rsp_valid [2];
    logic [31:0] o_rdata     [2];
    logic        o_err       [2];

    assign bus0.req_valid  = req_valid[0];
    assign bus0.req_we     = req_we[0];
    assign bus0.req_funct3 = req_f3[0];
    assign bus0.req_addr   = req_addr[0];
    assign bus0.req_wdata  = req_wdata[0];
    assign bus0.rsp_ready  = rsp_ready[0];
    assign bus3.req_valid  = req_valid[1];
    assign bus3.req_we     = req_we[1];
    assign bus3.req_funct3 = req_f3[1];
    assign bus3.req_addr   = req_addr[1];
    assign bus3.req_wdata  = req_wdata[1];
    assign bus3.rsp_ready  = rsp_ready[1];
    assign o_req_ready[0]  = bus0.req_ready;
    assign o_rsp_valid[0]  = bus0.rsp_valid;
    assign o_rdata[0]      = bus0.rsp_rdata;
    assign o_err[0]        = bus0.rsp_err;
    assign o_req_ready[1]  = bus3.req_ready;
    assign o_rsp_valid[1]  = bus3.rsp_valid;
    assign o_rdata[1]      = bus3.rsp_rdata;
    assign o_err[1]        = bus3.rsp_err;

    int total = 0;
    int bad   = 0;
    logic [32:0] exp0 [$];
    logic [32:0] exp1 [$];
    logic [7:0]  mdl [2][256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Byte-addressed model: returns {err, rdata} and applies stores to mdl.
    function automatic logic [32:0] model_op(input int d, input bit we, input logic [2:0] f3,
                                             input logic [31:0] addr, input logic [31:0] wd);
        int n;
        int a;
        bit bad_f3;
        logic [31:0] v;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        a = int'(addr[7:0]);
        if (we) bad_f3 = (f3 > 3'd2);
        else    bad_f3 = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        if ((addr >= 32'd256) || bad_f3 || ((a % n) != 0)) return {1'b1, 32'h0};
        if (we) begin
            for (int i = 0; i < n; i++) mdl[d][a + i] = wd[8*i +: 8];
            return {1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[d][a + i]) << (8 * i));
        if (!f3[2] && (n == 1) && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && (n == 2) && v[15]) v = v | 32'hFFFF_0000;
        return {1'b0, v};
    endfunction

    task automatic chk_reset(input int d);
        chk("rst_req_ready", 32'(o_req_ready[d]), 32'd1);
        chk("rst_rsp_valid", 32'(o_rsp_valid[d]), 32'd0);
        chk("rst_rsp_rdata", o_rdata[d], 32'd0);
        chk("rst_rsp_err",   32'(o_err[d]), 32'd0);
    endtask

    task automatic drive_req(input int d, input bit we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        int k;
        k = 0;
        while (!o_req_ready[d] && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) begin
            total++; bad++;
            $display("FAIL req_ready_timeout: dut %0d never ready", d);
        end
        req_we[d] = we; req_f3[d] = f3; req_addr[d] = addr; req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_we[d] = 1'($urandom); req_f3[d] = 3'($urandom);
        req_addr[d] = $urandom; req_wdata[d] = $urandom;
    endtask

    task automatic issue(input int d, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold, input bit use_c,
                         input logic [32:0] c_exp);
        logic [32:0] e;
        int k;
        e = model_op(d, we, f3, addr, wd);
        if (use_c) e = c_exp;
        if (d == 0) exp0.push_back(e); else exp1.push_back(e);
        drive_req(d, we, f3, addr, wd);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!o_rsp_valid[d] && k < 40);
        chk("latency", k, 32'(2 + ws_of(d)));
        chk("busy_req_ready", 32'(o_req_ready[d]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 32'(o_rsp_valid[d]), 32'd1);
            chk("hold_rdata", o_rdata[d], e[31:0]);
            chk("hold_err", 32'(o_err[d]), 32'(e[32]));
            @(posedge clk); #1;
            chk("hold_req_ready", 32'(o_req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        chk("valid_drop", 32'(o_rsp_valid[d]), 32'd0);
        chk("ready_back", 32'(o_req_ready[d]), 32'd1);
    endtask

    // Monitor: a response is consumed on the edge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (o_rsp_valid[d] && rsp_ready[d]) begin
                    logic [32:0] e;
                    if ((d == 0 && exp0.size() == 0) || (d == 1 && exp1.size() == 0)) begin
                        total++; bad++;
                        $display("FAIL unexpected_rsp: dut %0d rdata %h", d, o_rdata[d]);
                    end else begin
                        e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
                        chk("rsp_rdata", o_rdata[d], e[31:0]);
                        chk("rsp_err", 32'(o_err[d]), 32'(e[32]));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_f3[d] = 3'b000;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++)
                issue(d, 1'b1, 3'b010, 32'(w * 4), $urandom, 0, 1'b0, 33'h0);

        issue(0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 1, 1, {1'b0, 32'h0});
        issue(0, 0, 3'b010, 32'h10,  32'h0,        0, 1, {1'b0, 32'hDEADBEEF});
        issue(0, 1, 3'b000, 32'h11,  32'h12345680, 0, 1, {1'b0, 32'h0});
        issue(0, 0, 3'b010, 32'h10,  32'h0,        0, 1, {1'b0, 32'hDEAD80EF});
        issue(0, 0, 3'b000, 32'h11,  32'h0,        2, 1, {1'b0, 32'hFFFFFF80});
        issue(0, 0, 3'b100, 32'h11,  32'h0,        0, 1, {1'b0, 32'h00000080});
        issue(0, 1, 3'b001, 32'h22,  32'hABCD1234, 0, 1, {1'b0, 32'h0});
        issue(0, 0, 3'b001, 32'h22,  32'h0,        0, 1, {1'b0, 32'h00001234});
        issue(0, 0, 3'b001, 32'h21,  32'h0,        1, 1, {1'b1, 32'h0});
        issue(0, 1, 3'b010, 32'h22,  32'h55555555, 0, 1, {1'b1, 32'h0});
        issue(0, 0, 3'b010, 32'h20,  32'h0,        0, 0, 33'h0);
        issue(0, 0, 3'b010, 32'h100, 32'h0,        0, 1, {1'b1, 32'h0});
        issue(0, 1, 3'b010, 32'h100, 32'h77777777, 0, 1, {1'b1, 32'h0});
        issue(0, 0, 3'b010, 32'h0,   32'h0,        0, 0, 33'h0);
        issue(0, 0, 3'b011, 32'h0,   32'h0,        0, 1, {1'b1, 32'h0});
        issue(0, 1, 3'b100, 32'h4,   32'h0,        0, 1, {1'b1, 32'h0});
        issue(0, 0, 3'b010, 32'h4,   32'h0,        0, 0, 33'h0);
        issue(0, 0, 3'b101, 32'h22,  32'h0,        0, 1, {1'b0, 32'h00001234});
        issue(0, 0, 3'b010, 32'hFC,  32'h0,        0, 0, 33'h0);

        issue(1, 1, 3'b010, 32'h8, 32'h11111111, 0, 1, {1'b0, 32'h0});
        issue(1, 0, 3'b010, 32'h8, 32'h0,        5, 1, {1'b0, 32'h11111111});

        // Abort a store while it sits in WAIT; it must never reach the array.
        drive_req(1, 1'b1, 3'b010, 32'h8, 32'hAAAAAAAA);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset(1);
        chk_reset(0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 0, 3'b010, 32'h8, 32'h0, 0, 1, {1'b0, 32'h11111111});

        for (int i = 0; i < 150; i++) begin
            int d;
            d = int'($urandom_range(0, 1));
            issue(d, 1'($urandom), 3'($urandom), 32'($urandom_range(0, 32'h11F)), $urandom,
                  int'($urandom_range(0, 3)), 1'b0, 33'h0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drain", 32'(exp0.size() + exp1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
Parametrised successor to the single-cycle data memory. It adds a valid/ready request/response handshake and configurable wait states for modelling slow memory. It reports misaligned, unsupported and out-of-range accesses instead of silently wrapping. It sits between the RV32 core's MEM stage and the word-organised data RAM, handling SB/SH/SW and LB/LH/LW/LBU/LHU.

Parameters:
ADDR_WIDTH, 32, byte address width
MEM_WORDS, 64, depth in 32-bit words; power of 2, at least 4
WAIT_STATES, 0, extra cycles between accept and array access (0..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 load/store funct3
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data (low bytes used for SB/SH)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response
rsp_rdata  out  32  load result (extended); 0 for stores and errors
rsp_err  out  1  access rejected

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous assert, active-low, released synchronously by the system.
- Reset values:
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; wait counter = 0.
  - RAM contents are not reset.
- FSM states:
  - IDLE: req_ready = 1. On req_valid & req_ready, latch we/funct3/addr/wdata and compute err. Next state is WAIT if WAIT_STATES > 0, else ACCESS.
  - WAIT: counter counts 1..WAIT_STATES, then goes to ACCESS.
  - ACCESS:
    - If not err: a store writes the merged word to the RAM; a load registers the extracted, extended data into rsp_rdata.
    - If err: RAM is untouched and rsp_rdata = 0.
    - Always goes to RESP.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE with rsp_valid = 0 on the next cycle.
- req_ready is 0 in every state except IDLE. There is only one outstanding request; no back-to-back pipelining.
- Latency:
  - A request accepted at edge N gives rsp_valid high after edge N+2+WAIT_STATES.
  - Minimum throughput is one request per 4+WAIT_STATES cycles when rsp_ready is tied high.
- Error (err = 1) when any of:
  - Word index addr[ADDR_WIDTH-1:2] >= MEM_WORDS. There is no modulo wrap.
  - Halfword access (funct3 001/101) with addr[0] = 1.
  - Word access (010) with addr[1:0] != 0.
  - Load funct3 011, 110 or 111.
  - Store funct3 other than 000, 001 or 010.
- Store merge:
  - SB replaces byte lane addr[1:0].
  - SH replaces lanes {addr[1],0} and {addr[1],1}.
  - SW replaces the whole word.
  - Untouched lanes keep their prior value.
- Load extract:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW returns the full word.
- Little-endian: lane 0 = bits [7:0].
- Load after store to the same word: sequential by construction, so the new data is always returned.
- Reset mid-operation (any state): return to IDLE immediately and drop the response.
  - A store not yet in ACCESS is never written.
  - A store whose ACCESS edge completed stays written.
- req_* inputs are ignored outside IDLE. A change of req_valid while not ready has no effect.

Decomposition:
- Shared package data_mem_pkg holds:
  - funct3 constants F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101;
  - the state enumeration IDLE/WAIT/ACCESS/RESP.
- Sub-module data_mem_lane (combinational): inputs old_word, wdata, funct3, addr[1:0]; outputs merged_word, load_data, misalign.
- The top level holds the FSM, wait counter, range check and RAM.

Test Plan:
1. WAIT_STATES = 0: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata = 0xDEADBEEF, err = 0; rsp_valid rises 2 cycles after accept.
2. SB 0x80 @0x11 onto word 0xDEADBEEF -> word 0xDEAD80EF. Then LB @0x11 -> 0xFFFFFF80, LBU @0x11 -> 0x00000080.
3. SH 0x1234 @0x22, then LH @0x22 -> 0x00001234. LH @0x21 -> err = 1, rdata = 0. SW @0x22 -> err = 1 and word 0x20 unchanged.
4. MEM_WORDS = 64: LW @0x100 -> err = 1, word 0 unchanged. Load funct3 = 011 -> err = 1.
5. WAIT_STATES = 3, rsp_ready low for 5 cycles -> rsp_valid rises at accept+5, rdata/err held, req_ready stays 0 until the cycle after the rsp handshake.
6. Assert rst_n low during WAIT of SW 0xAAAAAAAA @0x8 (word previously 0x11111111) -> outputs at reset values immediately; after release, LW @0x8 -> 0x11111111.
